// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I datapath: PC, IR/OldPC/Data/A/B/ALUOut, 32x32 register file, immediate extender and ALU.
// Executes one controller control word per clk edge; memory port is unified with combinational read.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        AdrSrc,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        RegWrite,
  input  logic [1:0]  ResultSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ALUControl,
  input  logic [2:0]  ImmSrc,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        zero,
  output logic        branchLEG
);

  localparam int XLEN = 32;

  logic [XLEN-1:0] pc, old_pc, ir, data_r, a_r, b_r, alu_out;
  logic [XLEN-1:0] rf [0:31];
  logic [XLEN-1:0] imm_ext, src_a, src_b, alu_result, result, rd1, rd2;

  // x0 is hardwired to zero on both read ports
  assign rd1 = (ir[19:15] == 5'd0) ? '0 : rf[ir[19:15]];
  assign rd2 = (ir[24:20] == 5'd0) ? '0 : rf[ir[24:20]];

  always_comb begin
    imm_ext = '0;
    case (ImmSrc)
      3'b000:  imm_ext = {{20{ir[31]}}, ir[31:20]};
      3'b001:  imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'b010:  imm_ext = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      3'b011:  imm_ext = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      3'b100:  imm_ext = {ir[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    src_a = '0;
    case (ALUSrcA)
      2'b00:   src_a = pc;
      2'b01:   src_a = old_pc;
      2'b10:   src_a = a_r;
      default: src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (ALUSrcB)
      2'b00:   src_b = b_r;
      2'b01:   src_b = imm_ext;
      2'b10:   src_b = 32'd4;
      default: src_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      3'b010:  alu_result = src_a + src_b;
      3'b110:  alu_result = src_a - src_b;
      3'b000:  alu_result = src_a & src_b;
      3'b001:  alu_result = src_a | src_b;
      3'b011:  alu_result = src_a ^ src_b;
      3'b111:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (ResultSrc)
      2'b00:   result = alu_out;
      2'b01:   result = data_r;
      2'b10:   result = alu_result;
      default: result = imm_ext;
    endcase
  end

  assign mem_adr   = AdrSrc ? result : pc;
  assign mem_wd    = b_r;
  assign mem_we    = MemWrite;
  assign op        = ir[6:0];
  assign func3     = ir[14:12];
  assign func7     = ir[31:25];
  assign zero      = (alu_result == '0);
  assign branchLEG = $signed(src_a) < $signed(src_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      data_r  <= '0;
      a_r     <= '0;
      b_r     <= '0;
      alu_out <= '0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite) begin
        ir     <= mem_rd;
        old_pc <= pc;
      end
      data_r  <= mem_rd;
      a_r     <= rd1;
      b_r     <= rd2;
      alu_out <= alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite && (ir[11:7] != 5'd0)) begin
      rf[ir[11:7]] <= result;
    end
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Multi-cycle RV32I datapath that executes the control words produced by the multi-cycle controller FSM, one control word per clock. Holds PC, the non-architectural registers (IR, OldPC, Data, A, B, ALUOut) and the 32×32 register file. It contains the immediate extender and the ALU. It drives a single unified instruction/data memory port and returns the decode fields and ALU flags to the controller.

## Interface
- XLEN, 32, datapath width; fixed at 32 and not a user override.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  in  1 each  control strobes from the controller.
- ResultSrc, ALUSrcA, ALUSrcB  in  2 each  mux selects.
- ALUControl, ImmSrc  in  3 each  ALU operation and immediate format.
- mem_adr  out  32  memory address.
- mem_wd  out  32  store data, always equal to B.
- mem_we  out  1  equal to MemWrite.
- mem_rd  in  32  memory read data, combinational read.
- op  out  7  IR[6:0].
- func3  out  3  IR[14:12].
- func7  out  7  IR[31:25].
- zero  out  1  ALUResult == 0.
- branchLEG  out  1  A < B as a signed compare, computed from SrcA and SrcB.

## Operation
- **SrcA select (ALUSrcA):** 00 PC, 01 OldPC, 10 A, 11 zero.
- **SrcB select (ALUSrcB):** 00 B, 01 ImmExt, 10 constant 4, 11 zero.
- **ALU (ALUControl):**
  - 010 add; 110 sub; 000 and; 001 or; 011 xor.
  - 111 slt: signed, result is 32'd1 or 32'd0.
  - Any other code: result 0.
  - Arithmetic is mod 2^32 with no overflow flag.
- **Immediates (ImmSrc):**
  - 000 I: sext IR[31:20].
  - 001 S: sext {IR[31:25], IR[11:7]}.
  - 010 B: sext {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - 011 J: sext {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - 100 U: {IR[31:12], 12'b0}.
  - Other codes: 0.
- **Result select (ResultSrc):** 00 ALUOut, 01 Data, 10 ALUResult (combinational), 11 ImmExt.
- **Address select:** mem_adr = AdrSrc ? Result : PC.
- **Register updates:**
  - PC ← Result when PCWrite.
  - IR ← mem_rd and OldPC ← PC when IRWrite, updated on the same edge.
  - Data ← mem_rd, A ← RF[IR[19:15]], B ← RF[IR[24:20]], ALUOut ← ALUResult: every cycle, unconditionally.
  - RF[IR[11:7]] ← Result when RegWrite and rd ≠ 0.
- **Register file:** x0 always reads 0. Reads are asynchronous.
- **Reset:** with rst=1 at an edge, PC ← RESET_PC; IR, OldPC, Data, A, B, ALUOut ← 0; all RF entries ← 0.
  - Reset overrides every write strobe, including when asserted mid-instruction.
  - After reset, op = 7'b0000000.

## Timing
- **Reset values:**
  - mem_adr = RESET_PC when AdrSrc=0.
  - op/func3/func7 = 0; mem_we follows MemWrite directly.
  - zero/branchLEG are combinational from the reset register values and current selects.
- **Fetch cycle** (IRWrite=1, PCWrite=1, ResultSrc=10, SrcA=PC, SrcB=4):
  - On a single edge: IR ← M[PC], OldPC ← old PC, PC ← PC+4.
- **Decode fields:** op/func3/func7 are valid one cycle after fetch. A/B are valid two cycles after fetch.
- **Register file timing:**
  - A write is visible on the read ports the cycle after the edge.
  - A same-cycle read returns the pre-write value.
- **Memory timing:**
  - Load data is captured in Data one edge after mem_adr is presented.
  - A store occurs on the edge where MemWrite=1, at mem_adr = Result.
- **Branch:** PC ← ALUOut, the target computed during decode as OldPC+ImmB, when the controller asserts PCWrite. zero and branchLEG must settle in the same cycle as the A−B compare.
- **Flag behaviour:** no flag is registered; all flags are combinational from the current cycle.

## Test plan
- **Reset:** rst held 2 cycles mid-fetch, with PCWrite=1 and RegWrite=1.
  - Required: PC=0, IR=0, RF[5]=0, mem_adr=0.
  - After release, the first fetch returns M[0].
- **R-type add:** RF[1]=7, RF[2]=-3, instruction add x3,x1,x2 through fetch/decode/execute/writeback.
  - Required: RF[3]=4, PC=4 after 4 cycles.
  - Then the sub variant: RF[3]=10. slt with RF[1]=-1, RF[2]=1: RF[3]=1.
- **Load/store:** sw x2,8(x1) with x1=0x100, x2=0xDEADBEEF.
  - Required: mem write at 0x108 on the MemWrite edge.
  - Then lw x4,8(x1): RF[4]=0xDEADBEEF after the writeback cycle.
- **Branches:** beq x1,x1,-8 at PC=0x20: zero=1 and PC=0x18.
  - blt x1,x2 with x1=-5, x2=3: branchLEG=1.
  - bge with the same operands: branchLEG=1, so the controller leaves PC=0x24.
- **Jumps:**
  - jal x1,+16 at PC=0x40: RF[1]=0x44, PC=0x50.
  - jalr x5,4(x6) with x6=0x200: RF[5]=OldPC+4, PC=0x204.
- **lui and x0:** lui x7,0x12345: RF[7]=0x12345000.
  - Write to x0 with Result=0xFFFF: RF[0] still reads 0.
